// File: rtl/bus_slave_pkg.sv
// Shared types and helpers for the bus slave memory: FSM/op encodings,
// captured request payload and the byte-lane merge used on writes.
package bus_slave_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_ERR
    } op_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              cpu;
        op_t               op;
    } req_t;

    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/bus_slave_ram.sv
// DEPTH x 32 word RAM: byte-enable synchronous write, registered read whose
// output holds until the next read and can be forced to the error word.
module bus_slave_ram
    import bus_slave_pkg::*;
#(
    parameter int unsigned       DEPTH    = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [BE_W-1:0]          be,
    input  logic                     rd_en,
    input  logic                     rd_err,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] wr_word_d;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_comb begin
        wr_word_d = be_merge(mem_q[addr], wdata, be);
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_err ? ERR_DATA : mem_q[addr];
        end
    end

    // Array contents are deliberately not reset so they survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bus_slave_mem.sv
// Slave-side bus responder: captures a request in IDLE, counts wait states,
// commits to the RAM on the edge entering ACK and pulses ack_bus for a cycle.
module bus_slave_mem
    import bus_slave_pkg::*;
#(
    parameter int unsigned       DEPTH       = 256,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] PROT_BASE   = 32'h0000_0300,
    parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] add_bus,
    input  logic [BE_W-1:0]   byte_en,
    input  logic              wr_bus,
    input  logic              rd_bus,
    input  logic [DATA_W-1:0] data_bus_wr,
    input  logic              cpu_bus,
    output logic [DATA_W-1:0] data_bus_rd,
    output logic              ack_bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic               ack_q, ack_d;

    logic               req_valid;
    logic               out_of_range;
    logic               priv_denied;
    logic               access_ok;
    logic               commit;
    logic               ram_we;
    logic               ram_rd_en;
    logic               ram_rd_err;

    assign req_valid = rd_bus | wr_bus;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.addr  = add_bus;
                    req_d.be    = byte_en;
                    req_d.wdata = data_bus_wr;
                    req_d.cpu   = cpu_bus;
                    req_d.op    = (rd_bus && wr_bus) ? OP_ERR :
                                  (wr_bus ? OP_WR : OP_RD);
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    state_d     = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                // A withdrawn request wins over the final wait cycle.
                if (!req_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Checks use req_d so a zero-wait request is judged on the capture edge.
    always_comb begin
        out_of_range = req_d.addr[DATA_W-1:2] >= (DATA_W-2)'(DEPTH);
        priv_denied  = (req_d.addr >= PROT_BASE) && !req_d.cpu;
        access_ok    = !out_of_range && !priv_denied && (req_d.op != OP_ERR);
        commit       = (state_d == ACK) && !reset;
        ram_we       = commit && (req_d.op == OP_WR) && access_ok;
        ram_rd_en    = commit && (req_d.op != OP_WR);
        ram_rd_err   = !access_ok;
        ack_d        = commit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
        end
    end

    bus_slave_ram #(
        .DEPTH    (DEPTH),
        .ERR_DATA (ERR_DATA)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .addr    (req_d.addr[2 +: AW]),
        .we      (ram_we),
        .wdata   (req_d.wdata),
        .be      (req_d.be),
        .rd_en   (ram_rd_en),
        .rd_err  (ram_rd_err),
        .rd_data (data_bus_rd)
    );

    assign ack_bus = ack_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: a table of transactions on a 2-wait-state
// instance plus hand sequences for abort, reset-in-WAIT and zero-wait streaming.
module tb_bus_slave_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] add_bus;
    logic [3:0]  byte_en;
    logic [31:0] data_bus_wr;
    logic        cpu_bus;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] drd0, drd1;
    logic        ack0, ack1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_ack_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_slave_mem u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .add_bus     (add_bus),
        .byte_en     (byte_en),
        .wr_bus      (wr0),
        .rd_bus      (rd0),
        .data_bus_wr (data_bus_wr),
        .cpu_bus     (cpu_bus),
        .data_bus_rd (drd0),
        .ack_bus     (ack0)
    );

    bus_slave_mem #(.WAIT_CYCLES(0)) u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .add_bus     (add_bus),
        .byte_en     (byte_en),
        .wr_bus      (wr1),
        .rd_bus      (rd1),
        .data_bus_wr (data_bus_wr),
        .cpu_bus     (cpu_bus),
        .data_bus_rd (drd1),
        .ack_bus     (ack1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        cpu;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic cpu, input logic [31:0] exp_data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.be = be; v.cpu = cpu; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Present a request on one instance, wait (bounded) for ack, release it,
    // then step into the following IDLE cycle.
    task automatic txn(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic c,
                       output logic [31:0] rdat, output int lat);
        add_bus = a; data_bus_wr = d; byte_en = be; cpu_bus = c;
        if (sel) begin rd1 = rd; wr1 = wr; end
        else     begin rd0 = rd; wr0 = wr; end
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if ((sel ? ack1 : ack0) === 1'b1) begin
                lat = i;
                break;
            end
        end
        rdat = sel ? drd1 : drd0;
        last_ack_cyc = cyc;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse_width", 32'(sel ? ack1 : ack0), 32'd0);
    endtask

    initial begin
        logic [31:0] rdat;
        int          lat;
        int          first_ack;
        logic        seen_ack;

        reset = 1'b1;
        add_bus = '0; byte_en = '0; data_bus_wr = '0; cpu_bus = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack_w2", 32'(ack0), 32'd0);
        check("reset_data_w2", drd0, 32'h0);
        check("reset_ack_w0", 32'(ack1), 32'd0);
        check("reset_data_w0", drd1, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        //            rd    wr    addr          wdata          be     cpu   expected data_bus_rd
        vecs[0]  = mk(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 1'b0, 32'h0000_0000);
        vecs[1]  = mk(1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hA5A5_1234);
        vecs[2]  = mk(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 32'hA5A5_1234);
        vecs[3]  = mk(1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h5, 1'b0, 32'hA5A5_1234);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'h00FF_00FF);
        vecs[5]  = mk(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0055, 4'hF, 1'b1, 32'h00FF_00FF);
        vecs[6]  = mk(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0001, 4'hF, 1'b0, 32'h00FF_00FF);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0000_0300, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0000_0300, 32'h0,         4'hF, 1'b1, 32'h0000_0055);
        vecs[9]  = mk(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0001, 4'hF, 1'b1, 32'h0000_0055);
        vecs[10] = mk(1'b1, 1'b0, 32'h0000_0300, 32'h0,         4'hF, 1'b1, 32'h0000_0001);
        vecs[11] = mk(1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 1'b0, 32'h0000_0001);
        vecs[12] = mk(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 32'hDEAD_BEEF);
        vecs[13] = mk(1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'h00FF_00FF);
        vecs[14] = mk(1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h00FF_00FF);
        vecs[15] = mk(1'b1, 1'b0, 32'h0000_0400, 32'h0,         4'hF, 1'b1, 32'hDEAD_BEEF);
        vecs[16] = mk(1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'h1111_1111);
        vecs[17] = mk(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'h1111_1111);
        vecs[18] = mk(1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'h00FF_00FF);
        vecs[19] = mk(1'b0, 1'b1, 32'h0000_0020, 32'h2020_2020, 4'hF, 1'b0, 32'h00FF_00FF);
        vecs[20] = mk(1'b0, 1'b1, 32'h0000_0024, 32'h2424_2424, 4'hF, 1'b0, 32'h00FF_00FF);
        vecs[21] = mk(1'b0, 1'b1, 32'h0000_02FC, 32'h0000_0077, 4'hF, 1'b0, 32'h00FF_00FF);
        vecs[22] = mk(1'b1, 1'b0, 32'h0000_02FC, 32'h0,         4'hF, 1'b0, 32'h0000_0077);

        foreach (vecs[i]) begin
            txn(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].cpu, rdat, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_data", i), rdat, vecs[i].exp_data);
        end

        // Write to 0x20 withdrawn after one WAIT cycle: no ack, no write.
        add_bus = 32'h20; data_bus_wr = 32'hBADB_AD00; byte_en = 4'hF; cpu_bus = 1'b0;
        wr0 = 1'b1;
        @(posedge clk); #1;
        wr0 = 1'b0;
        seen_ack = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            seen_ack = seen_ack | ack0;
        end
        check("withdraw_no_ack", 32'(seen_ack), 32'd0);

        // Reset lands on the edge that would have entered ACK for a write to 0x24.
        add_bus = 32'h24; data_bus_wr = 32'hBAD0_0024; byte_en = 4'hF;
        wr0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_in_wait_ack", 32'(ack0), 32'd0);
        check("reset_in_wait_data", drd0, 32'h0);
        wr0 = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rdat, lat);
        check("withdraw_word", rdat, 32'h2020_2020);
        txn(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, 1'b0, rdat, lat);
        check("reset_word", rdat, 32'h2424_2424);
        check("reset_word_latency", 32'(lat), 32'd3);

        // Zero-wait instance: streamed reads one transaction per two cycles.
        txn(1'b1, 1'b0, 1'b1, 32'h0, 32'hA0A0_A0A0, 4'hF, 1'b0, rdat, lat);
        check("w0_wr0_latency", 32'(lat), 32'd1);
        txn(1'b1, 1'b0, 1'b1, 32'h4, 32'hB4B4_B4B4, 4'hF, 1'b0, rdat, lat);
        check("w0_wr0_held_data", rdat, 32'h0);
        txn(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rdat, lat);
        first_ack = last_ack_cyc;
        check("w0_rd0_latency", 32'(lat), 32'd1);
        check("w0_rd0_data", rdat, 32'hA0A0_A0A0);
        txn(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, rdat, lat);
        check("w0_rd4_data", rdat, 32'hB4B4_B4B4);
        check("w0_ack_spacing", 32'(last_ack_cyc - first_ack), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_slave_mem.md
# bus_slave_mem

Memory-mapped responder for the arbiter's slave-side bus: the single target that completes transactions the round-robin arbiter forwards on add_bus/rd_bus/wr_bus. Holds a word-addressed RAM with byte-enable writes, inserts a configurable number of wait states, and returns a one-cycle ack_bus pulse with read data. A high-address window is privileged and is only reachable when cpu_bus is high.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 2: wait states between request capture and ack; 0 to 15.
- PROT_BASE, 32'h0000_0300: byte addresses at or above this value are privileged.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on error or denied access.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- add_bus  in  32  byte address; bits [1:0] ignored; word index = add_bus[2 +: $clog2(DEPTH)].
- byte_en  in  4  write byte lanes; bit i maps to data bits [8i+7:8i]; ignored on reads.
- wr_bus  in  1  write request.
- rd_bus  in  1  read request.
- data_bus_wr  in  32  write data.
- cpu_bus  in  1  requester is CPU (privileged).
- data_bus_rd  out  32  read data; valid while ack_bus=1, held until next read completes.
- ack_bus  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: if (rd_bus|wr_bus) is sampled high, capture add_bus, byte_en, data_bus_wr, cpu_bus, and op; load wait counter with WAIT_CYCLES; go to WAIT, or to ACK if WAIT_CYCLES=0.
- WAIT: decrement counter each cycle; at 1, go to ACK. If rd_bus and wr_bus are both low (request withdrawn), abort to IDLE with no write and no ack.
- ACK: ack_bus=1 for exactly one cycle; unconditionally go to IDLE.
- Commit on the edge entering ACK:
  - Write: only lanes with byte_en=1 are updated.
  - Read: RAM word is registered into data_bus_rd.
- Error cases commit no write and return data_bus_rd=ERR_DATA on reads, but are still acked:
  - out of range: add_bus[31:2] >= DEPTH;
  - privileged: address >= PROT_BASE with captured cpu_bus=0.
- rd_bus and wr_bus both high: protocol error; no RAM access; acked with data_bus_rd=ERR_DATA.
- Write with byte_en=0: acked, RAM unchanged.
- Inputs are used only as captured in IDLE; changes to address or data during WAIT are ignored.

## Timing
- Reset values: ack_bus=0, data_bus_rd=32'h0, state=IDLE, counter=0. RAM contents are not reset and are retained across reset.
- Latency: request first sampled at edge E0; ack_bus is high in cycle E0+1+WAIT_CYCLES.
- The initiator holds the request and its fields until it samples ack_bus=1, then deasserts on the following cycle. The slave is back in IDLE in that cycle, so a new request presented there is accepted. Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
- A write's data is visible to a read whose IDLE capture happens at or after the write's ACK cycle.
- data_bus_rd changes only on read commit or reset; writes leave it unchanged.
- Reset asserted in any state: next cycle is IDLE with ack_bus=0. A write still in WAIT is discarded; a write already committed stays in RAM.

## Structure
- Package bus_slave_pkg:
  - state_t enum {IDLE, WAIT, ACK};
  - op_t enum {OP_RD, OP_WR, OP_ERR};
  - default ERR_DATA constant;
  - function be_merge(old, new, be) returning the 32-bit lane-merged word.
- One sub-module, bus_slave_ram: DEPTH x 32 array with synchronous byte-enable write and registered read, instantiated by bus_slave_mem. The FSM, wait counter, and access checks stay in the top.

## Test plan
- WAIT_CYCLES=2: write 32'hA5A5_1234 to 0x10 with byte_en=4'hF, cpu_bus=0 -> ack in cycle 3 after request; read 0x10 -> data_bus_rd=32'hA5A5_1234 with ack 3 cycles later.
- Write 32'hFFFF_FFFF to 0x10 with byte_en=4'b0101 over existing 32'h0000_0000 -> read returns 32'h00FF_00FF.
- Write 32'h1 to 0x300:
  - with cpu_bus=0 -> acked; read with cpu_bus=0 returns 32'hDEAD_BEEF;
  - repeat with cpu_bus=1 -> read with cpu_bus=1 returns 32'h1.
- rd_bus=wr_bus=1, then address 0x400 (out of range, DEPTH=256) -> both acked with 32'hDEAD_BEEF; prior RAM contents unchanged.
- Write request withdrawn after one WAIT cycle -> no ack; RAM word unchanged. Separately, reset pulsed during WAIT of a write -> ack_bus=0 next cycle; target word unchanged on a later read.
- WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 with the next request issued the cycle after each ack -> acks 2 cycles apart with correct data each.
